shift595_ctrl: RTL and testbench

//  Serial shift-out sequencer for an external 74HC595-style register chain (dat/cp/latch pins).

---
 rtl/shift595_ctrl.sv | 122 ++++++++++++
 tb/tb_shift595_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift595_ctrl.sv
// Serial shift-out sequencer for a 74HC595-style chain: shifts a word out on dat_o/cp_o with
// programmable half-period, then strobes lat_o and pulses done_o.
module shift595_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              dat_o,
    output logic              cp_o,
    output logic              lat_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StShiftLo, StShiftHi, StLatch} state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shreg_q;

    logic              phase_end;
    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] load_rest;
    logic [DATA_W-1:0] shreg_adv;

    assign phase_end = (div_cnt_q == DIV_LAST);

    // shreg_q holds only the bits not yet driven, so the next bit always sits at the exit end.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit = data_i[DATA_W-1];
            load_rest = data_i << 1;
            next_bit  = shreg_q[DATA_W-1];
            shreg_adv = shreg_q << 1;
        end else begin
            first_bit = data_i[0];
            load_rest = data_i >> 1;
            next_bit  = shreg_q[0];
            shreg_adv = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            dat_o     <= 1'b0;
            cp_o      <= 1'b0;
            lat_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        shreg_q   <= load_rest;
                        dat_o     <= first_bit;
                        cp_o      <= 1'b0;
                        busy_o    <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= StShiftLo;
                    end
                end
                StShiftLo: begin
                    if (phase_end) begin
                        cp_o      <= 1'b1;
                        div_cnt_q <= '0;
                        state_q   <= StShiftHi;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StShiftHi: begin
                    if (phase_end) begin
                        cp_o      <= 1'b0;
                        div_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            dat_o   <= 1'b0;
                            lat_o   <= 1'b1;
                            state_q <= StLatch;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            dat_o     <= next_bit;
                            shreg_q   <= shreg_adv;
                            state_q   <= StShiftLo;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StLatch: begin
                    if (phase_end) begin
                        lat_o     <= 1'b0;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        div_cnt_q <= '0;
                        state_q   <= StIdle;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift595_ctrl.sv
// Bench for shift595_ctrl: three instances (MSB/div4, LSB/div4, MSB/div1) share stimulus and are
// checked every cycle against a timeline model, plus literal checks per scenario.
module tb_shift595_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  data;
    logic [2:0]    busy, done, dat, cp, lat;

    always #5 clk = ~clk;

    shift595_ctrl #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_msb4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
        .busy_o(busy[0]), .done_o(done[0]), .dat_o(dat[0]), .cp_o(cp[0]), .lat_o(lat[0])
    );
    shift595_ctrl #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_lsb4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
        .busy_o(busy[1]), .done_o(done[1]), .dat_o(dat[1]), .cp_o(cp[1]), .lat_o(lat[1])
    );
    shift595_ctrl #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_msb1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
        .busy_o(busy[2]), .done_o(done[2]), .dat_o(dat[2]), .cp_o(cp[2]), .lat_o(lat[2])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: a transfer is a timeline indexed by cycles since the accepting edge.
    bit          m_act  [3];
    bit          m_done [3];
    int          m_k    [3];
    logic [W-1:0] m_word [3];

    // Observed-pin statistics.
    int           rises [3];
    int           lat_cyc [3];
    int           lat_pulses [3];
    int           done_cnt [3];
    int           busy_run [3];
    int           last_run [3];
    logic [W-1:0] col [3];
    logic         cp_prev [3];
    logic         lat_prev [3];

    int s_rises [3];
    int s_latc [3];
    int s_latp [3];
    int s_done [3];

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit msb_of(input int i);
        return (i != 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b0;
            end else if (m_act[i]) begin
                m_k[i]++;
                m_done[i] = 1'b0;
                if (m_k[i] == (2 * W + 1) * div_of(i)) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    m_act[i]  = 1'b1;
                    m_k[i]    = 0;
                    m_word[i] = data;
                end
            end
        end
    endtask

    // {busy, done, dat, cp, lat}
    function automatic logic [4:0] model_out(input int i);
        int seg;
        int idx;
        logic [4:0] r;
        r = {1'b0, m_done[i], 3'b000};
        if (m_act[i]) begin
            r[4] = 1'b1;
            seg  = m_k[i] / div_of(i);
            if (seg < 2 * W) begin
                idx  = seg / 2;
                r[1] = (seg % 2 == 1);
                r[2] = msb_of(i) ? m_word[i][W-1-idx] : m_word[i][idx];
            end else begin
                r[0] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic monitor();
        for (int i = 0; i < 3; i++) begin
            if (cp[i] && !cp_prev[i]) begin
                rises[i]++;
                col[i] = {col[i][W-2:0], dat[i]};
            end
            if (lat[i]) lat_cyc[i]++;
            if (lat[i] && !lat_prev[i]) lat_pulses[i]++;
            if (done[i]) done_cnt[i]++;
            if (busy[i]) begin
                busy_run[i]++;
            end else if (busy_run[i] != 0) begin
                last_run[i] = busy_run[i];
                busy_run[i] = 0;
            end
            cp_prev[i]  = cp[i];
            lat_prev[i] = lat[i];
        end
    endtask

    // Model advances at the edge; DUT pins are compared at the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pins[%0d]", i), {27'd0, busy[i], done[i], dat[i], cp[i], lat[i]},
                  {27'd0, model_out(i)});
        end
        monitor();
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            s_rises[i] = rises[i];
            s_latc[i]  = lat_cyc[i];
            s_latp[i]  = lat_pulses[i];
            s_done[i]  = done_cnt[i];
        end
    endtask

    task automatic go(input logic [W-1:0] word);
        data  = word;
        start = 1'b1;
        tick();
        start = 1'b0;
        data  = '0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_done[i] = 0; m_k[i] = 0; m_word[i] = '0;
            rises[i] = 0; lat_cyc[i] = 0; lat_pulses[i] = 0; done_cnt[i] = 0;
            busy_run[i] = 0; last_run[i] = 0; col[i] = '0; cp_prev[i] = 0; lat_prev[i] = 0;
        end
        rst   = 1'b1;
        start = 1'b1;
        data  = 16'hFFFF;
        tick();
        tick();
        check("reset_pins", {17'd0, busy, done, dat, cp, lat}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_after_reset", {17'd0, busy, done, dat, cp, lat}, 32'd0);

        // Basic MSB-first transfer
        snap();
        go(16'hA5C3);
        run(140);
        check("basic_rises", rises[0] - s_rises[0], 16);
        check("basic_bits", col[0], 16'hA5C3);
        check("basic_busy_len", last_run[0], 132);
        check("basic_lat_cycles", lat_cyc[0] - s_latc[0], 4);
        check("basic_lat_pulses", lat_pulses[0] - s_latp[0], 1);
        check("basic_done", done_cnt[0] - s_done[0], 1);
        check("basic_lsb_bits", col[1], 16'hC3A5);
        check("basic_div1_bits", col[2], 16'hA5C3);
        check("basic_div1_busy_len", last_run[2], 33);

        // LSB-first with a single set bit
        snap();
        go(16'h0001);
        run(140);
        check("lsb_bits", col[1], 16'h8000);
        check("lsb_rises", rises[1] - s_rises[1], 16);
        check("msb_0001_bits", col[0], 16'h0001);

        // Start while busy is ignored
        snap();
        go(16'h0000);
        run(49);
        go(16'hFFFF);
        run(100);
        check("busy_ign_bits", col[0], 16'h0000);
        check("busy_ign_done", done_cnt[0] - s_done[0], 1);
        check("busy_ign_rises", rises[0] - s_rises[0], 16);
        check("busy_ign_div1_done", done_cnt[2] - s_done[2], 2);
        check("busy_ign_div1_bits", col[2], 16'hFFFF);

        // Back-to-back: second start in the done cycle
        snap();
        go(16'h5A5A);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            tick();
            if (done[0]) found = 1'b1;
        end
        check("b2b_done_seen", {31'd0, found}, 32'd1);
        check("b2b_first_bits", col[0], 16'h5A5A);
        go(16'h1234);
        check("b2b_busy_again", {31'd0, busy[0]}, 32'd1);
        run(140);
        check("b2b_second_bits", col[0], 16'h1234);
        check("b2b_lat_pulses", lat_pulses[0] - s_latp[0], 2);
        check("b2b_done", done_cnt[0] - s_done[0], 2);
        check("b2b_busy_len", last_run[0], 132);

        // Abort by reset mid-transfer, then a fresh transfer
        snap();
        go(16'hFFFF);
        run(39);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_pins", {17'd0, busy, done, dat, cp, lat}, 32'd0);
        check("abort_no_latch", lat_pulses[0] - s_latp[0], 0);
        check("abort_no_done", done_cnt[0] - s_done[0], 0);
        snap();
        go(16'hA5C3);
        run(140);
        check("post_abort_div1_busy_len", last_run[2], 33);
        check("post_abort_div1_bits", col[2], 16'hA5C3);
        check("post_abort_div1_done", done_cnt[2] - s_done[2], 1);
        check("post_abort_bits", col[0], 16'hA5C3);
        check("post_abort_done", done_cnt[0] - s_done[0], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
